scr1_pipe_sleep_ctrl: RTL and testbench

//  Pipe-side initiator of the clock-gating sleep/wake handshake. Turns a retired WFI into a

---
 rtl/scr1_pipe_sleep_ctrl.sv | 134 +++++++++++++
 tb/tb_scr1_pipe_sleep_ctrl.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/scr1_pipe_sleep_ctrl.sv
// scr1_pipe_sleep_ctrl: pipe-side WFI sequencer that drains the pipe, requests clock gating,
// and requests wake-up on an interrupt or debug halt request. Runs on the always-on clock.
`default_nettype none

module scr1_pipe_sleep_ctrl #(
  parameter int SLEEP_EN     = 1,
  parameter int IDLE_TIMEOUT = 255,
  parameter int WAKE_HOLD    = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic wfi_i,
  input  logic dbg_mode_i,
  input  logic pipe_idle_i,
  input  logic irq_pending_i,
  input  logic dbg_halt_req_i,
  input  logic clk_en_i,
  output logic sleep_req_o,
  output logic wake_req_o,
  output logic fetch_stall_o,
  output logic wfi_done_o
);

  // One counter serves both the drain timeout and the wake hold time.
  localparam int TO_W_RAW   = $clog2(IDLE_TIMEOUT + 1);
  localparam int HOLD_W_RAW = $clog2(WAKE_HOLD + 1);
  localparam int MAX_W      = (TO_W_RAW > HOLD_W_RAW) ? TO_W_RAW : HOLD_W_RAW;
  localparam int CNT_W      = (MAX_W < 1) ? 1 : MAX_W;

  localparam logic [CNT_W-1:0] TO_LAST   = CNT_W'((IDLE_TIMEOUT > 0) ? IDLE_TIMEOUT - 1 : 0);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'((WAKE_HOLD > 0) ? WAKE_HOLD - 1 : 0);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;

  typedef enum logic [2:0] {
    S_RUN      = 3'd0,
    S_DRAIN    = 3'd1,
    S_SLEEP    = 3'd2,
    S_ASLEEP   = 3'd3,
    S_WAKE     = 3'd4,
    S_WFI_HALT = 3'd5
  } state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt, cnt_inc;
  logic             done_nxt;
  logic             wake_evt;

  assign wake_evt = irq_pending_i | dbg_halt_req_i;
  assign cnt_inc  = (cnt == CNT_MAX) ? cnt : cnt + 1'b1;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    done_nxt  = 1'b0;
    case (state)
      S_RUN: begin
        if (wfi_i) begin
          if (dbg_mode_i | wake_evt) begin
            done_nxt = 1'b1;
          end else begin
            state_nxt = S_DRAIN;
            cnt_nxt   = '0;
          end
        end
      end
      S_DRAIN: begin
        cnt_nxt = cnt_inc;
        if (wake_evt) begin
          state_nxt = S_RUN;
          done_nxt  = 1'b1;
        end else if (pipe_idle_i) begin
          state_nxt = (SLEEP_EN != 0) ? S_SLEEP : S_WFI_HALT;
        end else if ((IDLE_TIMEOUT != 0) && (cnt == TO_LAST)) begin
          state_nxt = S_WFI_HALT;
        end
      end
      S_SLEEP: begin
        if (wake_evt) begin
          state_nxt = S_WAKE;
          cnt_nxt   = '0;
        end else if (!clk_en_i) begin
          state_nxt = S_ASLEEP;
        end
      end
      S_ASLEEP: begin
        if (wake_evt) begin
          state_nxt = S_WAKE;
          cnt_nxt   = '0;
        end else if (clk_en_i) begin
          // Clock came back without a wake event of ours: stay halted until one arrives.
          state_nxt = S_WFI_HALT;
        end
      end
      S_WAKE: begin
        cnt_nxt = cnt_inc;
        if (clk_en_i && (cnt >= HOLD_LAST)) begin
          state_nxt = S_RUN;
          done_nxt  = 1'b1;
        end
      end
      S_WFI_HALT: begin
        if (wake_evt) begin
          state_nxt = S_RUN;
          done_nxt  = 1'b1;
        end
      end
      default: begin
        state_nxt = S_RUN;
      end
    endcase
  end

  // Outputs are decoded from the next state and registered alongside it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= S_RUN;
      cnt           <= '0;
      sleep_req_o   <= 1'b0;
      wake_req_o    <= 1'b0;
      fetch_stall_o <= 1'b0;
      wfi_done_o    <= 1'b0;
    end else begin
      state         <= state_nxt;
      cnt           <= cnt_nxt;
      sleep_req_o   <= (state_nxt == S_SLEEP);
      wake_req_o    <= (state_nxt == S_WAKE);
      fetch_stall_o <= (state_nxt != S_RUN);
      wfi_done_o    <= done_nxt;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_scr1_pipe_sleep_ctrl.sv
// Directed bench for scr1_pipe_sleep_ctrl: one sleeping instance and one SLEEP_EN=0 instance.
`default_nettype none

module tb_scr1_pipe_sleep_ctrl;

  logic clk = 1'b0;
  logic rst, wfi, dbg_mode, pipe_idle, irq, dbg_halt, clk_en;
  logic s0, w0, st0, d0;
  logic s1, w1, st1, d1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  scr1_pipe_sleep_ctrl #(.SLEEP_EN(1), .IDLE_TIMEOUT(4), .WAKE_HOLD(2)) u_dut (
    .clk(clk), .rst(rst), .wfi_i(wfi), .dbg_mode_i(dbg_mode), .pipe_idle_i(pipe_idle),
    .irq_pending_i(irq), .dbg_halt_req_i(dbg_halt), .clk_en_i(clk_en),
    .sleep_req_o(s0), .wake_req_o(w0), .fetch_stall_o(st0), .wfi_done_o(d0)
  );

  scr1_pipe_sleep_ctrl #(.SLEEP_EN(0), .IDLE_TIMEOUT(4), .WAKE_HOLD(2)) u_nosleep (
    .clk(clk), .rst(rst), .wfi_i(wfi), .dbg_mode_i(dbg_mode), .pipe_idle_i(pipe_idle),
    .irq_pending_i(irq), .dbg_halt_req_i(dbg_halt), .clk_en_i(clk_en),
    .sleep_req_o(s1), .wake_req_o(w1), .fetch_stall_o(st1), .wfi_done_o(d1)
  );

  // Output vectors are {sleep_req, wake_req, fetch_stall, wfi_done}.
  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; wfi = 1'b0; dbg_mode = 1'b0; pipe_idle = 1'b1;
    irq = 1'b0; dbg_halt = 1'b0; clk_en = 1'b1;
    #12;
    chk("reset_u0", {s0, w0, st0, d0}, 4'b0000);
    chk("reset_u1", {s1, w1, st1, d1}, 4'b0000);
    @(negedge clk); rst = 1'b0;
    step();
    chk("run_idle", {s0, w0, st0, d0}, 4'b0000);

    // Full sleep / wake round trip
    wfi = 1'b1; step(); chk("s1_drain", {s0, w0, st0, d0}, 4'b0010);
    wfi = 1'b0; step(); chk("s1_sleep", {s0, w0, st0, d0}, 4'b1010);
    step();             chk("s1_sleep_hold", {s0, w0, st0, d0}, 4'b1010);
    clk_en = 1'b0; step(); chk("s1_asleep", {s0, w0, st0, d0}, 4'b0010);
    step();             chk("s1_asleep_hold", {s0, w0, st0, d0}, 4'b0010);
    irq = 1'b1; step(); chk("s1_wake", {s0, w0, st0, d0}, 4'b0110);
    irq = 1'b0; clk_en = 1'b1;
    step();             chk("s1_wake_hold", {s0, w0, st0, d0}, 4'b0110);
    step();             chk("s1_done", {s0, w0, st0, d0}, 4'b0001);
    step();             chk("s1_run", {s0, w0, st0, d0}, 4'b0000);

    // WFI treated as NOP
    irq = 1'b1; wfi = 1'b1; step(); chk("s2_irq_nop", {s0, w0, st0, d0}, 4'b0001);
    irq = 1'b0; wfi = 1'b0; step(); chk("s2_irq_after", {s0, w0, st0, d0}, 4'b0000);
    dbg_mode = 1'b1; wfi = 1'b1; step(); chk("s2_dbg_nop", {s0, w0, st0, d0}, 4'b0001);
    dbg_mode = 1'b0; wfi = 1'b0; step(); chk("s2_dbg_after", {s0, w0, st0, d0}, 4'b0000);

    // Drain timeout with a busy pipe
    pipe_idle = 1'b0;
    wfi = 1'b1; step(); chk("s3_drain", {s0, w0, st0, d0}, 4'b0010);
    wfi = 1'b0;
    step(); step(); step();
    chk("s3_drain_late", {s0, w0, st0, d0}, 4'b0010);
    step(); chk("s3_halt", {s0, w0, st0, d0}, 4'b0010);
    pipe_idle = 1'b1;
    step(); chk("s3_halt_ignores_idle", {s0, w0, st0, d0}, 4'b0010);
    dbg_halt = 1'b1; step(); chk("s3_dbg_wake", {s0, w0, st0, d0}, 4'b0001);
    dbg_halt = 1'b0; step(); chk("s3_run", {s0, w0, st0, d0}, 4'b0000);

    // Wake event while still in SLEEP
    wfi = 1'b1; step(); wfi = 1'b0;
    step(); chk("s4_sleep", {s0, w0, st0, d0}, 4'b1010);
    irq = 1'b1; step(); chk("s4_wake", {s0, w0, st0, d0}, 4'b0110);
    irq = 1'b0; step(); chk("s4_wake_hold", {s0, w0, st0, d0}, 4'b0110);
    step(); chk("s4_done", {s0, w0, st0, d0}, 4'b0001);
    step(); chk("s4_run", {s0, w0, st0, d0}, 4'b0000);

    // Foreign wake: clock returns without a wake event
    wfi = 1'b1; step(); wfi = 1'b0; step();
    clk_en = 1'b0; step(); chk("s6_asleep", {s0, w0, st0, d0}, 4'b0010);
    clk_en = 1'b1; step(); chk("s6_halt", {s0, w0, st0, d0}, 4'b0010);
    irq = 1'b1; step(); chk("s6_halt_exit", {s0, w0, st0, d0}, 4'b0001);
    irq = 1'b0; step(); chk("s6_run", {s0, w0, st0, d0}, 4'b0000);

    // Asynchronous reset in WAKE and in ASLEEP
    wfi = 1'b1; step(); wfi = 1'b0; step();
    clk_en = 1'b0; step();
    irq = 1'b1; step(); chk("s5_pre_wake", {s0, w0, st0, d0}, 4'b0110);
    #2 rst = 1'b1; #1;
    chk("s5_rst_wake", {s0, w0, st0, d0}, 4'b0000);
    @(negedge clk); rst = 1'b0; irq = 1'b0;
    step(); chk("s5_after_rst_wake", {s0, w0, st0, d0}, 4'b0000);
    clk_en = 1'b1;
    wfi = 1'b1; step(); wfi = 1'b0; step();
    clk_en = 1'b0; step(); chk("s5_pre_asleep", {s0, w0, st0, d0}, 4'b0010);
    #2 rst = 1'b1; #1;
    chk("s5_rst_asleep", {s0, w0, st0, d0}, 4'b0000);
    @(negedge clk); rst = 1'b0; clk_en = 1'b1;
    step(); chk("s5_after_rst_asleep", {s0, w0, st0, d0}, 4'b0000);

    // SLEEP_EN=0 instance: same entry sequence ends in WFI_HALT
    chk("s5b_reset", {s1, w1, st1, d1}, 4'b0000);
    wfi = 1'b1; step(); chk("s5b_drain", {s1, w1, st1, d1}, 4'b0010);
    wfi = 1'b0; step(); chk("s5b_halt", {s1, w1, st1, d1}, 4'b0010);
    step();             chk("s5b_halt_hold", {s1, w1, st1, d1}, 4'b0010);
    irq = 1'b1; step(); chk("s5b_done", {s1, w1, st1, d1}, 4'b0001);
    irq = 1'b0; step(); chk("s5b_run", {s1, w1, st1, d1}, 4'b0000);
    repeat (4) step();

    // Random stress on the request/stall invariants
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      wfi       = ($urandom_range(0, 5) == 0);
      irq       = ($urandom_range(0, 7) == 0);
      dbg_halt  = ($urandom_range(0, 15) == 0);
      pipe_idle = ($urandom_range(0, 2) != 0);
      clk_en    = ($urandom_range(0, 3) != 0);
      #6;
      chk("inv_req_excl", {3'b000, s0 & w0}, 4'b0000);
      chk("inv_done_run", {3'b000, d0 & st0}, 4'b0000);
      chk("inv_req_stall", {3'b000, (s0 | w0) & ~st0}, 4'b0000);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
